// File: rtl/wall_probe_scheduler.sv
// wall_probe_scheduler
//   Once per start request, scans 8 wall probes around each of two sprites
//   (16 cycles) through a single shared playfield lookup. It then publishes
//   the per-sprite wall-contact flags together, with a one-cycle done pulse.
// Ports:
//   clk, reset (async, active low)
//   start                      : request a scan (dropped while busy)
//   spr0_x/y, spr1_x/y [8:0]   : sprite top-left positions, latched on accept
//   probe_hpos/vpos [8:0] (out): lookup address, 0 outside SCAN
//   probe_hit                  : wall bit for the current address (same cycle)
//   busy, done                 : scan in progress / flags-updated pulse
//   spr0_flag, spr1_flag [7:0] : contact flags, bit k = probe k
module wall_probe_scheduler #(
  parameter int SPR0_W = 10,
  parameter int SPR0_H = 9,
  parameter int SPR1_W = 14,
  parameter int SPR1_H = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] spr0_x,
  input  logic [8:0] spr0_y,
  input  logic [8:0] spr1_x,
  input  logic [8:0] spr1_y,
  output logic [8:0] probe_hpos,
  output logic [8:0] probe_vpos,
  input  logic       probe_hit,
  output logic       busy,
  output logic       done,
  output logic [7:0] spr0_flag,
  output logic [7:0] spr1_flag
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t     r_state, w_next;
  logic [3:0] r_cnt;
  logic [8:0] r_x0, r_y0, r_x1, r_y1;
  logic [7:0] r_sh0, r_sh1;
  logic [7:0] r_f0, r_f1;
  logic       r_busy, r_done;

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = SCAN;
      SCAN:    if (r_cnt == 4'd15) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Datapath: position latch, probe counter, shadows, flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_x0   <= '0;
      r_y0   <= '0;
      r_x1   <= '0;
      r_y1   <= '0;
      r_sh0  <= '0;
      r_sh1  <= '0;
      r_f0   <= '0;
      r_f1   <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      // busy/done are registered copies of the next state
      r_busy <= (w_next != IDLE);
      r_done <= (w_next == DONE);
      if (r_state == IDLE && start) begin
        r_x0  <= spr0_x;
        r_y0  <= spr0_y;
        r_x1  <= spr1_x;
        r_y1  <= spr1_y;
        r_cnt <= '0;
      end
      if (r_state == SCAN) begin
        r_cnt <= r_cnt + 4'd1;
        if (!r_cnt[3]) r_sh0[r_cnt[2:0]] <= probe_hit;
        else           r_sh1[r_cnt[2:0]] <= probe_hit;
        // Last probe: its hit bit goes straight into the published flags
        // because the shadow write lands on the same edge.
        if (r_cnt == 4'd15) begin
          r_f0 <= r_sh0;
          r_f1 <= {probe_hit, r_sh1[6:0]};
        end
      end
    end
  end

  // Probe address generation, all arithmetic wraps at 9 bits
  logic [8:0] w_x, w_y, w_w, w_h, w_hpos, w_vpos;

  always_comb begin
    w_x    = r_cnt[3] ? r_x1 : r_x0;
    w_y    = r_cnt[3] ? r_y1 : r_y0;
    w_w    = r_cnt[3] ? 9'(SPR1_W) : 9'(SPR0_W);
    w_h    = r_cnt[3] ? 9'(SPR1_H) : 9'(SPR0_H);
    w_hpos = '0;
    w_vpos = '0;
    case (r_cnt[2:0])
      3'd0: begin w_hpos = w_x - 9'd1;       w_vpos = w_y;          end
      3'd1: begin w_hpos = w_x - 9'd1;       w_vpos = w_y + 9'd8;   end
      3'd2: begin w_hpos = w_x + w_w;        w_vpos = w_y;          end
      3'd3: begin w_hpos = w_x + w_w;        w_vpos = w_y + 9'd8;   end
      3'd4: begin w_hpos = w_x;              w_vpos = w_y - 9'd1;   end
      3'd5: begin w_hpos = w_x + w_w - 9'd1; w_vpos = w_y - 9'd1;   end
      3'd6: begin w_hpos = w_x;              w_vpos = w_y + w_h;    end
      3'd7: begin w_hpos = w_x + w_w - 9'd1; w_vpos = w_y + w_h;    end
      default: ;
    endcase
  end

  assign probe_hpos = (r_state == SCAN) ? w_hpos : 9'd0;
  assign probe_vpos = (r_state == SCAN) ? w_vpos : 9'd0;
  assign busy       = r_busy;
  assign done       = r_done;
  assign spr0_flag  = r_f0;
  assign spr1_flag  = r_f1;

endmodule

// File: tb/tb_wall_probe_scheduler.sv
module tb_wall_probe_scheduler;

  logic       clk, reset, start, probe_hit, busy, done;
  logic [8:0] spr0_x, spr0_y, spr1_x, spr1_y, probe_hpos, probe_vpos;
  logic [7:0] spr0_flag, spr1_flag;
  int         tot = 0;
  int         bad = 0;
  int         mode = 0;  // 0: no walls, 1: hpos==219|vpos==223, 2: hpos==511, 3: all walls

  wall_probe_scheduler dut (
    .clk(clk), .reset(reset), .start(start),
    .spr0_x(spr0_x), .spr0_y(spr0_y), .spr1_x(spr1_x), .spr1_y(spr1_y),
    .probe_hpos(probe_hpos), .probe_vpos(probe_vpos), .probe_hit(probe_hit),
    .busy(busy), .done(done), .spr0_flag(spr0_flag), .spr1_flag(spr1_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Playfield model
  always_comb begin
    probe_hit = 1'b0;
    case (mode)
      1: probe_hit = (probe_hpos == 9'd219) || (probe_vpos == 9'd223);
      2: probe_hit = (probe_hpos == 9'd511);
      3: probe_hit = 1'b1;
      default: probe_hit = 1'b0;
    endcase
  end

  task automatic set_std_pos();
    spr0_x = 9'd220; spr0_y = 9'd30; spr1_x = 9'd20; spr1_y = 9'd215;
  endtask

  task automatic test_reset();
    #12;
    tot++;
    if ({busy, done, spr0_flag, spr1_flag, probe_hpos, probe_vpos} !== '0) begin
      bad++;
      $display("FAIL reset_state: busy=%b done=%b f0=%h f1=%h pos=(%0d,%0d) want all 0",
               busy, done, spr0_flag, spr1_flag, probe_hpos, probe_vpos);
    end
  endtask

  // Also covers start accepted in the first cycle after reset release
  task automatic test_probe_seq();
    logic [8:0] eh[16] = '{219,219,230,230,220,229,220,229, 19,19,34,34,20,33,20,33};
    logic [8:0] ev[16] = '{30,38,30,38,29,29,39,39, 215,223,215,223,214,214,223,223};
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b1; mode = 0; set_std_pos();
    @(posedge clk); #1;
    start = 1'b0;
    spr0_x = 9'd100; spr0_y = 9'd100; spr1_x = 9'd100; spr1_y = 9'd100;
    for (int i = 0; i < 16; i++) begin
      tot++;
      if ({probe_hpos, probe_vpos, busy, done} !== {eh[i], ev[i], 2'b10}) begin
        bad++;
        $display("FAIL seq_probe%0d: got (%0d,%0d) busy=%b done=%b want (%0d,%0d) busy=1 done=0",
                 i, probe_hpos, probe_vpos, busy, done, eh[i], ev[i]);
      end
      @(posedge clk); #1;
    end
    tot++;
    if ({done, busy, spr0_flag, spr1_flag} !== {2'b11, 16'h0000}) begin
      bad++;
      $display("FAIL seq_done: done=%b busy=%b f0=%h f1=%h want done=1 busy=1 00/00",
               done, busy, spr0_flag, spr1_flag);
    end
    @(posedge clk); #1;
    tot++;
    if ({done, busy, probe_hpos, probe_vpos} !== '0) begin
      bad++;
      $display("FAIL seq_idle: done=%b busy=%b pos=(%0d,%0d) want 0,0,(0,0)",
               done, busy, probe_hpos, probe_vpos);
    end
  endtask

  task automatic test_flags();
    set_std_pos(); mode = 1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) begin
        tot++;
        if ({spr0_flag, spr1_flag} !== 16'h0000) begin
          bad++;
          $display("FAIL flags_hold_scan: f0=%h f1=%h want 00/00", spr0_flag, spr1_flag);
        end
      end
      @(posedge clk); #1;
    end
    tot++;
    if ({done, spr0_flag, spr1_flag} !== {1'b1, 8'h03, 8'hCA}) begin
      bad++;
      $display("FAIL flags_map: done=%b f0=%h f1=%h want done=1 03/ca", done, spr0_flag, spr1_flag);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    spr0_x = 9'd0; spr0_y = 9'd0; spr1_x = 9'd20; spr1_y = 9'd215;
    mode = 2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 0) begin
        tot++;
        if ({probe_hpos, probe_vpos} !== {9'd511, 9'd0}) begin
          bad++;
          $display("FAIL wrap_p0: got (%0d,%0d) want (511,0)", probe_hpos, probe_vpos);
        end
      end
      if (i == 4) begin
        tot++;
        if ({probe_hpos, probe_vpos} !== {9'd0, 9'd511}) begin
          bad++;
          $display("FAIL wrap_p4: got (%0d,%0d) want (0,511)", probe_hpos, probe_vpos);
        end
      end
      @(posedge clk); #1;
    end
    tot++;
    if ({done, spr0_flag, spr1_flag} !== {1'b1, 8'h03, 8'h00}) begin
      bad++;
      $display("FAIL wrap_flags: done=%b f0=%h f1=%h want done=1 03/00", done, spr0_flag, spr1_flag);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int npulse = 0;
    int d1 = -1;
    int d2 = -1;
    logic [15:0] expf;
    bit drained = 0;
    set_std_pos(); mode = 1; start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (done) begin
        npulse++;
        if (d1 < 0) d1 = c; else if (d2 < 0) d2 = c;
      end
      expf = (c < 17) ? 16'h0300 : 16'h03CA;
      tot++;
      if ({spr0_flag, spr1_flag} !== expf) begin
        bad++;
        $display("FAIL b2b_flags_c%0d: got %h%h want %h", c, spr0_flag, spr1_flag, expf);
      end
    end
    start = 1'b0;
    tot++;
    if (npulse != 2 || d1 != 17 || d2 - d1 != 18) begin
      bad++;
      $display("FAIL b2b_pulses: count=%0d first=%0d gap=%0d want 2, 17, 18", npulse, d1, d2 - d1);
    end
    for (int c = 0; c < 40 && !drained; c++) begin
      @(posedge clk); #1;
      if (!busy) drained = 1;
    end
    tot++;
    if (!drained) begin
      bad++;
      $display("FAIL b2b_drain: busy=%b want 0 within 40 cycles", busy);
    end
  endtask

  task automatic test_reset_mid();
    int npulse = 0;
    set_std_pos(); mode = 3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    tot++;
    if ({done, spr0_flag, spr1_flag} !== {1'b1, 16'hFFFF}) begin
      bad++;
      $display("FAIL rst_pre_flags: done=%b f0=%h f1=%h want done=1 ff/ff", done, spr0_flag, spr1_flag);
    end
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    tot++;
    if ({busy, done, spr0_flag, spr1_flag, probe_hpos, probe_vpos} !== '0) begin
      bad++;
      $display("FAIL rst_async: busy=%b done=%b f0=%h f1=%h pos=(%0d,%0d) want all 0",
               busy, done, spr0_flag, spr1_flag, probe_hpos, probe_vpos);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (done) npulse++;
    end
    tot++;
    if (npulse != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_no_done: pulses=%0d busy=%b want 0, 0", npulse, busy);
    end
    mode = 1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    tot++;
    if ({done, spr0_flag, spr1_flag} !== {1'b1, 8'h03, 8'hCA}) begin
      bad++;
      $display("FAIL rst_recover: done=%b f0=%h f1=%h want done=1 03/ca", done, spr0_flag, spr1_flag);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; mode = 0;
    spr0_x = '0; spr0_y = '0; spr1_x = '0; spr1_y = '0;
    test_reset();
    test_probe_seq();
    test_flags();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
